pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/address width in bits (min 28).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, 2..16).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold PC, suppress all state updates this cycle.
REQ-007 SHALL have port npc_op  input  3  next-PC select: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JUMPR, 4 JAL, 5 RET; 6-7 reserved.
REQ-008 SHALL have port imm  input  26  instruction immediate; [15:0] branch offset, [25:0] jump target.
REQ-009 SHALL have port jrs  input  WIDTH  register-file value for JUMPR/RET.
REQ-010 SHALL have port pc  output  WIDTH  current PC (registered).
REQ-011 SHALL have port npc  output  WIDTH  combinational next PC.
REQ-012 SHALL have port ras_empty / ras_full  output  1 each  stack occupancy flags.
REQ-013 SHALL have port ras_mismatch  output  1  registered pulse: last RET's stack value differed from jrs.

Function
REQ-014 SHALL compute pc4 = pc + 4 modulo 2^WIDTH.
REQ-015 SHALL select npc: PLUS4 pc4; BRANCH pc4 + sign-extended {imm[15:0],2'b00}; JUMP and JAL {pc4[WIDTH-1:28], imm, 2'b00}; JUMPR jrs; RET per REQ-020/REQ-026; reserved codes pc4.
REQ-016 SHALL load pc <= npc on each rising clk edge where stall = 0; pc holds when stall = 1.
REQ-017 SHALL make npc valid in the same cycle as npc_op (zero latency); the new PC is visible on pc one cycle later.
REQ-018 SHALL, on JAL with stall = 0, push pc4 onto the RAS.
REQ-019 SHALL implement the RAS as a circular buffer with a top pointer and a count saturating at RAS_DEPTH; a push when full overwrites the oldest entry, and count stays at RAS_DEPTH.
REQ-020 SHALL, on RET with stall = 0 and RAS non-empty, set npc = top entry and pop (count - 1).
REQ-021 SHALL, on RET with an empty RAS, set npc = jrs, leave count at 0, and set ras_mismatch = 0.
REQ-022 SHALL set ras_mismatch = 1 for exactly one cycle after a non-stalled RET that popped a value differing from jrs; npc still follows the popped value.
REQ-023 SHALL make ras_empty = (count == 0) and ras_full = (count == RAS_DEPTH), both combinational from registered state.
REQ-024 SHALL, when stall = 1, perform no push, no pop, and no ras_mismatch assertion; npc still reflects npc_op combinationally.

Reset
REQ-025 SHALL, while rstn = 0 and independent of clk, force pc = RESET_PC, RAS count = 0, top pointer = 0, and ras_mismatch = 0; RAS entry contents are don't-care. Reset asserted mid-stream discards all stacked returns, and the first cycle after release fetches RESET_PC.

Configuration
REQ-026 SHALL compile the RAS in only when PC_UNIT_RAS_EN is defined; without it, RET behaves exactly as JUMPR (npc = jrs), JAL pushes nothing, ras_empty = 1, ras_full = 0, ras_mismatch = 0, and no RAS storage is synthesised.

Structure
REQ-027 SHALL place the npc_op encodings (NPC_PLUS4 .. NPC_RET) in the shared control-encoding definitions alongside the existing NPC codes; existing codes 0-3 keep their values.
REQ-028 SHALL implement the stack as one sub-module, ras_stack (parameter DEPTH, WIDTH; push, pop, din, top, empty, full), instantiated under PC_UNIT_RAS_EN.

Verification
REQ-029 SHALL cover reset: rstn low mid-run -> pc = 32'h0000_3000 immediately; ras_empty = 1.
REQ-030 SHALL cover branch: pc = 32'h3000, BRANCH, imm[15:0] = 16'hFFFF -> npc = 32'h3000; imm = 16'h0002 -> npc = 32'h300C.
REQ-031 SHALL cover call/return: JAL at pc = 32'h3010 with imm = 26'h0000C40 -> pc = 32'h3100; then RET with jrs = 32'h3014 -> pc = 32'h3014, ras_mismatch = 0, ras_empty = 1.
REQ-032 SHALL cover overflow: 5 JALs from pcs 0x3000, 0x3010, 0x3020, 0x3030, 0x3040 with depth 4 -> ras_full = 1; 4 RETs return 0x3044, 0x3034, 0x3024, 0x3014; a 5th RET uses jrs.
REQ-033 SHALL cover mismatch and stall: RET with stack top 32'h3014 and jrs = 32'h4000 -> pc = 32'h3014 and a one-cycle ras_mismatch; RET held under stall = 1 for 3 cycles -> pc, count, and ras_mismatch unchanged.
REQ-034 SHALL cover the macro-off build: RET with jrs = 32'h5000 -> pc = 32'h5000; flags held constant.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC select encodings shared by fetch control.
// Codes 0-3 are the legacy NPC set; JAL/RET extend it.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JUMPR  = 3'd3,
    NPC_JAL    = 3'd4,
    NPC_RET    = 3'd5
  } npc_op_e;

  localparam int IMM_W    = 26;
  localparam int BOFF_W   = 16;
  localparam int JSEG_LSB = 28;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack with a saturating count.
// A push into a full stack overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp;
  logic [PW-1:0]    tp_up;
  logic [CW-1:0]    cnt;

  assign tp_up = tp + 1'b1;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign top   = mem[tp];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push) begin
      tp <= tp_up;
      if (!full)
        cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      tp  <= tp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Entry contents need no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[tp_up] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC mux and optional return stack.
// Define PC_UNIT_RAS_EN to build in the return-address stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int             WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter int             RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] jrs,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_mismatch
);

  localparam logic [WIDTH-1:0] HI_MASK =
    ~WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] ret_tgt;

  logic op_br;
  logic op_jmp;
  logic op_jr;
  logic op_jal;
  logic op_ret;

  assign op_br  = (npc_op == NPC_BRANCH);
  assign op_jmp = (npc_op == NPC_JUMP);
  assign op_jr  = (npc_op == NPC_JUMPR);
  assign op_jal = (npc_op == NPC_JAL);
  assign op_ret = (npc_op == NPC_RET);

  assign pc4    = pc + WIDTH'(4);
  assign br_off = {{(WIDTH-18){imm[15]}},
                   imm[15:0], 2'b00};
  assign br_tgt = pc4 + br_off;

  // Jumps keep the 256 MiB segment of the fall-through PC.
  assign j_tgt  = (pc4 & HI_MASK) |
                  WIDTH'({imm, 2'b00});

  always_comb begin
    npc = pc4;
    unique case (1'b1)
      op_br:           npc = br_tgt;
      op_jmp, op_jal:  npc = j_tgt;
      op_jr:           npc = jrs;
      op_ret:          npc = ret_tgt;
      default:         npc = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pc <= RESET_PC;
    else if (!stall)
      pc <= npc;
  end

`ifdef PC_UNIT_RAS_EN
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             mm_q;

  assign ras_push = op_jal && !stall;
  assign ras_pop  = op_ret && !stall;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign ret_tgt = ras_empty ? jrs : ras_top;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      mm_q <= 1'b0;
    else
      mm_q <= ras_pop && !ras_empty &&
              (ras_top != jrs);
  end

  assign ras_mismatch = mm_q;
`else
  assign ret_tgt      = jrs;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks against a queue-based model.
// Honours PC_UNIT_RAS_EN the same way the design does.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic [25:0] imm = '0;
  logic [31:0] jrs = '0;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_mismatch;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] q[$];
  logic        m_mm;

  pc_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .npc_op       (npc_op),
    .imm          (imm),
    .jrs          (jrs),
    .pc           (pc),
    .npc          (npc),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_mismatch (ras_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(
    input logic [2:0] op,
    input logic [25:0] im,
    input logic [31:0] j);
    logic [31:0] p4;
    int off;
    p4 = m_pc + 32'd4;
    off = $signed(im[15:0]) * 4;
    case (op)
      3'd1: return p4 + 32'(off);
      3'd2, 3'd4:
        return (p4 & 32'hF000_0000) + {4'h0, im, 2'b00};
      3'd3: return j;
      3'd5: begin
`ifdef PC_UNIT_RAS_EN
        if (q.size() > 0) return q[$];
`endif
        return j;
      end
      default: return p4;
    endcase
  endfunction

  task automatic step(input logic [2:0] op,
                      input logic [25:0] im,
                      input logic [31:0] j,
                      input logic st);
    logic [31:0] e;
    npc_op = op; imm = im; jrs = j; stall = st;
    #1;
    e = ref_npc(op, im, j);
    chk("npc", npc, e);
    @(posedge clk);
    #1;
    m_mm = 1'b0;
    if (!st) begin
`ifdef PC_UNIT_RAS_EN
      if (op == 3'd4) begin
        if (q.size() == 4) void'(q.pop_front());
        q.push_back(m_pc + 32'd4);
      end
      if (op == 3'd5 && q.size() > 0) begin
        m_mm = (q[$] != j);
        void'(q.pop_back());
      end
`endif
      m_pc = e;
    end
    chk("pc", pc, m_pc);
    chk("empty", 32'(ras_empty), 32'(q.size() == 0));
    chk("full", 32'(ras_full), 32'(q.size() == 4));
    chk("mism", 32'(ras_mismatch), 32'(m_mm));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    q.delete();
    m_pc = 32'h0000_3000;
    m_mm = 1'b0;
    chk("rst_pc", pc, m_pc);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_mism", 32'(ras_mismatch), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [31:0] ovf_exp [4];

  initial begin
    ovf_exp[0] = 32'h3044; ovf_exp[1] = 32'h3034;
    ovf_exp[2] = 32'h3024; ovf_exp[3] = 32'h3014;
    m_pc = 32'h0000_3000;
    m_mm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // branch offsets with pc held by stall
    step(3'd1, 26'h000FFFF, 32'h0, 1'b1);
    chk("br_m1", npc, 32'h3000);
    step(3'd1, 26'h0000002, 32'h0, 1'b1);

    // call / return
    step(3'd3, 26'h0, 32'h3010, 1'b0);
    step(3'd4, 26'h0000C40, 32'h0, 1'b0);
    chk("jal_pc", pc, 32'h3100);
    step(3'd5, 26'h0, 32'h3014, 1'b0);
    chk("ret_pc", pc, 32'h3014);

    // overflow
    for (int k = 0; k < 5; k++) begin
      step(3'd3, 26'h0, 32'h3000 + 32'(16 * k), 1'b0);
      step(3'd4, 26'h0000C40, 32'h0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(3'd5, 26'h0, 32'h0000_7000, 1'b0);
`ifdef PC_UNIT_RAS_EN
      chk("ovf_ret", pc, ovf_exp[k]);
`endif
    end
    step(3'd5, 26'h0, 32'h0000_7100, 1'b0);
    chk("ovf_jrs", pc, 32'h7100);

    // mismatch, then stalled RET
    step(3'd3, 26'h0, 32'h3010, 1'b0);
    step(3'd4, 26'h0000C40, 32'h0, 1'b0);
    step(3'd5, 26'h0, 32'h4000, 1'b0);
    step(3'd0, 26'h0, 32'h0, 1'b0);
    step(3'd3, 26'h0, 32'h3010, 1'b0);
    step(3'd4, 26'h0000C40, 32'h0, 1'b0);
    repeat (3) step(3'd5, 26'h0, 32'h3014, 1'b1);
    step(3'd5, 26'h0, 32'h3014, 1'b0);

    // RET on empty stack follows jrs
    step(3'd5, 26'h0, 32'h5000, 1'b0);
    chk("ret_5000", pc, 32'h5000);

    // reset mid-stream with pending returns
    step(3'd4, 26'h0000C40, 32'h0, 1'b0);
    do_reset();
    step(3'd0, 26'h0, 32'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic [31:0] j;
      op = 3'($urandom_range(0, 7));
      j  = $urandom;
      if (op == 3'd5 && q.size() > 0 &&
          $urandom_range(0, 1) == 1)
        j = q[$];
      if (i == 200) begin
        do_reset();
      end
      step(op, 26'($urandom), j,
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
